uart_rx: RTL and testbench

8N1 UART receiver for the board's `UART_RXD` pin; it is the receive-side counterpart of the UART transmitter driving `UART_TXD`. It synchronises the asynchronous serial line and qualifies the start bit at mid-bit. Each bit is sampled once at its centre. Received bytes are presented on a valid/ready handshake to the core logic running on the system clock, with framing-error and overrun reporting.

---
 rtl/uart_rx.sv | 101 ++++++++++
 tb/tb_uart_rx.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser, mid-bit start qualification and
// centre sampling, with a one-entry valid/ready output slot and error pulses.
module uart_rx #(
  parameter int CLKS_PER_BIT = 938
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       frame_err,
  output logic       overrun
);
  localparam int HALF = CLKS_PER_BIT / 2 - 1;
  localparam int CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;

  state_t        state;
  logic          sync1, rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      sync1     <= 1'b1;
      rx_s      <= 1'b1;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      sync1     <= rxd;
      rx_s      <= sync1;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      // A byte loading on the same edge overrides this clear below.
      if (valid && ready) valid <= 1'b0;

      case (state)
        IDLE: begin
          if (!rx_s) begin
            state <= START;
            cnt   <= '0;
          end
        end
        START: begin
          if (cnt == CNT_HALF) begin
            cnt     <= '0;
            bit_idx <= '0;
            state   <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DATA: begin
          if (cnt == CNT_LAST) begin
            shreg   <= {rx_s, shreg[7:1]};
            cnt     <= '0;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= STOP;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              if (!valid || ready) begin
                data  <= shreg;
                valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BRK;
            end
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        BRK: begin
          // Hold off start detection until the line has been released.
          if (rx_s) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are serialised bit by bit, the expected
// outcome (byte, framing error or overrun) and its cycle are queued per frame.
module tb_uart_rx;
  localparam int N   = 16;
  localparam int H   = N / 2 - 1;
  localparam int LAT = 3 + H + 9 * N;
  localparam int K_BYTE = 0, K_FE = 1, K_OV = 2;

  logic       clk = 1'b0;
  logic       rst, rxd, ready;
  logic [7:0] data;
  logic       valid, frame_err, overrun;

  uart_rx #(.CLKS_PER_BIT(N)) dut (
    .clk(clk), .rst(rst), .rxd(rxd), .data(data), .valid(valid),
    .ready(ready), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int kind; logic [7:0] d; int at;} ev_t;
  ev_t exp_q[$];
  int  n_cmp = 0, n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  task automatic got(input int k, input logic [7:0] d);
    ev_t e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_event: kind %0d data %0h at cycle %0d, none expected", k, d, cyc);
    end else begin
      e = exp_q.pop_front();
      chk("event_kind", k, e.kind);
      if (k == K_BYTE) chk("event_data", {24'd0, d}, {24'd0, e.d});
      chk("event_cycle", cyc, e.at);
    end
  endtask

  // Monitor: a new byte is valid rising, or valid held across an accept edge.
  logic pv = 1'b0, pacc = 1'b0;
  always @(negedge clk) begin
    if (!rst) begin
      if (valid && (!pv || pacc)) got(K_BYTE, data);
      if (frame_err) got(K_FE, 8'h00);
      if (overrun) got(K_OV, 8'h00);
    end
    pv   = valid;
    pacc = valid && ready;
  end

  // Called on a negedge; the start edge t0 is the following posedge.
  task automatic send_frame(input logic [7:0] b, input bit stop_ok, input int extra_low);
    logic [9:0] bits;
    bits = {stop_ok, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      repeat (N) @(negedge clk);
    end
    if (!stop_ok) repeat (extra_low) @(negedge clk);
    rxd = 1'b1;
  endtask

  task automatic frame(input logic [7:0] b, input bit stop_ok, input int extra_low, input int kind);
    exp_q.push_back('{kind: kind, d: b, at: cyc + 1 + LAT});
    send_frame(b, stop_ok, extra_low);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int t0;
    logic [7:0] rb;
    bit ok;
    rst = 1'b1; rxd = 1'b1; ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_data", {24'd0, data}, 32'd0);
    chk("reset_valid", valid, 0);
    chk("reset_frame_err", frame_err, 0);
    chk("reset_overrun", overrun, 0);
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Basic receive with backpressure, then a single accept.
    frame(8'hA5, 1, 0, K_BYTE);
    for (int i = 0; i < 100; i++) begin
      chk("hold_valid", valid, 1);
      chk("hold_data", {24'd0, data}, 32'hA5);
      @(negedge clk);
    end
    ready = 1'b1;
    @(negedge clk);
    ready = 1'b0;
    chk("accept_clears_valid", valid, 0);

    // Glitch shorter than half a bit.
    repeat (4) @(negedge clk);
    rxd = 1'b0;
    repeat (5) @(negedge clk);
    rxd = 1'b1;
    repeat (30) @(negedge clk);
    chk("glitch_no_valid", valid, 0);
    ready = 1'b1;
    frame(8'h3C, 1, 0, K_BYTE);
    repeat (5) @(negedge clk);

    // Framing error with the line held low well past the stop bit.
    frame(8'h55, 0, 40, K_FE);
    chk("fe_no_valid", valid, 0);
    repeat (4) @(negedge clk);
    frame(8'h81, 1, 0, K_BYTE);
    repeat (5) @(negedge clk);
    ready = 1'b0;

    // Back-to-back frames with no consumer: second one overruns.
    frame(8'h12, 1, 0, K_BYTE);
    frame(8'h34, 1, 0, K_OV);
    chk("overrun_keeps_valid", valid, 1);
    chk("overrun_keeps_data", {24'd0, data}, 32'h12);

    // Accept on exactly the stop-sample cycle of the next byte.
    t0 = cyc + 1;
    fork
      frame(8'h34, 1, 0, K_BYTE);
      begin
        while (cyc < t0 + LAT - 1) @(negedge clk);
        ready = 1'b1;
        @(negedge clk);
        ready = 1'b0;
      end
    join
    chk("collision_valid", valid, 1);
    chk("collision_data", {24'd0, data}, 32'h34);

    // Reset during data bit 3 of a frame whose remaining bits are all high.
    repeat (4) @(negedge clk);
    t0 = cyc + 1;
    fork
      send_frame(8'hF8, 1, 0);
      begin
        while (cyc < t0 + 4 * N + 8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midreset_valid", valid, 0);
        chk("midreset_data", {24'd0, data}, 32'd0);
        chk("midreset_flags", {30'd0, frame_err, overrun}, 32'd0);
      end
    join
    repeat (5) @(negedge clk);
    ready = 1'b1;
    frame(8'hF0, 1, 0, K_BYTE);

    // Random frames, occasional bad stop bit, random inter-frame gaps.
    for (int i = 0; i < 20; i++) begin
      rb = 8'($urandom);
      ok = ($urandom_range(0, 7) != 0);
      frame(rb, ok, $urandom_range(0, 30), ok ? K_BYTE : K_FE);
      repeat (ok ? $urandom_range(0, 20) : $urandom_range(4, 20)) @(negedge clk);
    end

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
